// File: rtl/fetch_pkg.sv
// Shared encodings and BTB entry layout for the fetch PC unit.
package fetch_pkg;

  // Entry fields are sized for the widest supported XLEN; narrower builds zero-extend.
  localparam int unsigned BTB_XLEN_MAX = 64;

  typedef enum logic [1:0] {
    SEL_JAL  = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_NONE = 2'd2
  } ex_sel_e;

  typedef struct packed {
    logic                    valid;
    logic [BTB_XLEN_MAX-1:0] tag;
    logic [BTB_XLEN_MAX-1:0] target;
  } btb_entry_t;

  function automatic logic is_redirect(input logic [1:0] sel);
    return (sel == SEL_JAL) || (sel == SEL_ALU);
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered update,
// asynchronous clear on rst_n.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_hit_c,
  output logic [XLEN-1:0] lk_target_c,
  input  logic            upd_write,
  input  logic            upd_inv,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  btb_entry_t mem [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] upd_tag;
  btb_entry_t       lk_e;
  btb_entry_t       upd_e;
  logic             upd_hit;
  logic             unused_ok;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[XLEN-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

  // Fetch addresses are word aligned; the low bits never select anything.
  assign unused_ok = ^{lk_pc[1:0], upd_pc[1:0]};

  // Lookup reads the stored array, so a same-cycle write is not visible.
  assign lk_e        = mem[lk_idx];
  assign lk_hit_c    = lk_e.valid && (lk_e.tag == BTB_XLEN_MAX'(lk_tag));
  assign lk_target_c = XLEN'(lk_e.target);

  assign upd_e   = mem[upd_idx];
  assign upd_hit = upd_e.valid && (upd_e.tag == BTB_XLEN_MAX'(upd_tag));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        mem[i] <= '0;
      end
    end else if (upd_write) begin
      mem[upd_idx] <= '{valid: 1'b1,
                        tag: BTB_XLEN_MAX'(upd_tag),
                        target: BTB_XLEN_MAX'(upd_target)};
    end else if (upd_inv && upd_hit) begin
      mem[upd_idx].valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: execute-stage redirect, optional BTB prediction, PC+4.
// Define FETCH_BTB_EN to build the branch target buffer.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned    XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h4000_0000),
  parameter int unsigned    BTB_ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_ready,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_out,
  input  logic            ex_valid,
  input  logic [1:0]      ex_sel,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_alu,
  output logic            flush,
  output logic            misaligned
);

  logic            redirect;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pred_pc;
  logic [XLEN-1:0] pc_next;
  logic            mis_next;

  // Redirect target selection and next-PC priority: redirect > prediction > hold.
  always_comb begin
    redirect   = 1'b0;
    raw_target = ex_alu;
    pc_next    = pc_out;
    if (ex_sel == SEL_JAL) begin
      raw_target = ex_pc + ex_imm;
    end
    redirect = ex_valid && is_redirect(ex_sel);
    target   = {raw_target[XLEN-1:2], 2'b00};
    mis_next = redirect && (raw_target[1:0] != 2'b00);
    if (redirect) begin
      pc_next = target;
    end else if (pc_valid && fetch_ready) begin
      pc_next = pred_pc;
    end
  end

`ifdef FETCH_BTB_EN
  logic            btb_hit;
  logic [XLEN-1:0] btb_target;

  fetch_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .lk_pc       (pc_out),
    .lk_hit_c    (btb_hit),
    .lk_target_c (btb_target),
    .upd_write   (redirect),
    .upd_inv     (ex_valid && !is_redirect(ex_sel)),
    .upd_pc      (ex_pc),
    .upd_target  (target)
  );

  assign pred_pc = btb_hit ? btb_target : pc_out + XLEN'(4);
`else
  assign pred_pc = pc_out + XLEN'(4);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out     <= RESET_PC;
      pc_valid   <= 1'b0;
      flush      <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      pc_out     <= pc_next;
      pc_valid   <= 1'b1;
      flush      <= redirect;
      misaligned <= mis_next;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: vector table driven through a scoreboard,
// plus reset-during-stall and reset-during-redirect sequences.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
`ifdef FETCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_ready;
  logic        pc_valid;
  logic [31:0] pc_out;
  logic        ex_valid;
  logic [1:0]  ex_sel;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_alu;
  logic        flush;
  logic        misaligned;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_ready (fetch_ready),
    .pc_valid    (pc_valid),
    .pc_out      (pc_out),
    .ex_valid    (ex_valid),
    .ex_sel      (ex_sel),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_alu      (ex_alu),
    .flush       (flush),
    .misaligned  (misaligned)
  );

  typedef struct {
    logic        fr;
    logic        exv;
    logic [1:0]  sel;
    logic [31:0] epc;
    logic [31:0] eimm;
    logic [31:0] ealu;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_flush;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic add(input logic fr, input logic exv, input logic [1:0] sel,
                     input logic [31:0] epc, input logic [31:0] eimm, input logic [31:0] ealu,
                     input logic [31:0] pc, input logic f, input logic m);
    vec_t v;
    v.fr = fr; v.exv = exv; v.sel = sel; v.epc = epc; v.eimm = eimm; v.ealu = ealu;
    v.exp_pc = pc; v.exp_valid = 1'b1; v.exp_flush = f; v.exp_mis = m;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    fetch_ready = v.fr;
    ex_valid    = v.exv;
    ex_sel      = v.sel;
    ex_pc       = v.epc;
    ex_imm      = v.eimm;
    ex_alu      = v.ealu;
    e.pc = v.exp_pc; e.valid = v.exp_valid; e.flush = v.exp_flush; e.mis = v.exp_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", idx);
    end else begin
      got = sb.pop_front();
      check($sformatf("pc_out[%0d]", idx), pc_out, got.pc);
      check($sformatf("pc_valid[%0d]", idx), 32'(pc_valid), 32'(got.valid));
      check($sformatf("flush[%0d]", idx), 32'(flush), 32'(got.flush));
      check($sformatf("misaligned[%0d]", idx), 32'(misaligned), 32'(got.mis));
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_sel = 2'd2; ex_pc = '0; ex_imm = '0; ex_alu = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_ready = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc_out, RST_PC);
    check("reset_valid", 32'(pc_valid), 32'd0);
    check("reset_flush", 32'(flush), 32'd0);
    check("reset_mis", 32'(misaligned), 32'd0);

    // fr exv sel  ex_pc         ex_imm       ex_alu        -> pc_out       flush mis
    add(1, 0, 2, 32'h0,         32'h0,       32'h0,         32'h4000_0000, 0, 0);
    add(1, 0, 2, 32'h0,         32'h0,       32'h0,         32'h4000_0004, 0, 0);
    add(1, 0, 2, 32'h0,         32'h0,       32'h0,         32'h4000_0008, 0, 0);
    add(0, 0, 2, 32'h0,         32'h0,       32'h0,         32'h4000_0008, 0, 0);
    add(0, 1, 0, 32'h4000_0010, 32'h20,      32'h0,         32'h4000_0030, 1, 0);
    add(0, 0, 2, 32'h0,         32'h0,       32'h0,         32'h4000_0030, 0, 0);
    add(1, 1, 1, 32'h4000_0200, 32'h0,       32'h4000_0102, 32'h4000_0100, 1, 1);
    add(1, 0, 2, 32'h0,         32'h0,       32'h0,         32'h4000_0104, 0, 0);
    add(1, 1, 2, 32'h4000_0010, 32'h0,       32'h0,         32'h4000_0108, 0, 0);
    add(1, 1, 3, 32'h4000_0000, 32'h0,       32'h0,         32'h4000_010C, 0, 0);
    add(1, 1, 0, 32'h4000_0008, 32'h38,      32'h0,         32'h4000_0040, 1, 0);
    add(1, 1, 1, 32'h4000_0300, 32'h0,       32'h4000_0008, 32'h4000_0008, 1, 0);
    add(1, 0, 2, 32'h0,         32'h0,       32'h0,         BTB_ON ? 32'h4000_0040 : 32'h4000_000C, 0, 0);
    add(1, 1, 1, 32'h4000_0300, 32'h0,       32'h4000_0008, 32'h4000_0008, 1, 0);
    add(1, 1, 2, 32'h4000_0008, 32'h0,       32'h0,         BTB_ON ? 32'h4000_0040 : 32'h4000_000C, 0, 0);
    add(1, 1, 1, 32'h4000_0300, 32'h0,       32'h4000_0008, 32'h4000_0008, 1, 0);
    add(1, 0, 2, 32'h0,         32'h0,       32'h0,         32'h4000_000C, 0, 0);
    add(1, 1, 1, 32'h4000_0400, 32'h0,       32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0);
    add(1, 0, 2, 32'h0,         32'h0,       32'h0,         32'h0000_0000, 0, 0);
    add(1, 0, 2, 32'h0,         32'h0,       32'h0,         32'h0000_0004, 0, 0);
    add(1, 1, 0, 32'hFFFF_FFF0, 32'h20,      32'h0,         32'h0000_0010, 1, 0);
    add(0, 0, 2, 32'h0,         32'h0,       32'h0,         32'h0000_0010, 0, 0);
    add(1, 0, 2, 32'h0,         32'h0,       32'h0,         32'h0000_0014, 0, 0);
    add(1, 1, 0, 32'h4000_0008, 32'h38,      32'h0,         32'h4000_0040, 1, 0);
    add(0, 0, 2, 32'h0,         32'h0,       32'h0,         32'h4000_0040, 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // Reset in the middle of a stall takes effect without a clock edge.
    fetch_ready = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("stall_rst_pc", pc_out, RST_PC);
    check("stall_rst_valid", 32'(pc_valid), 32'd0);
    check("stall_rst_flush", 32'(flush), 32'd0);

    // A redirect presented while reset is held is discarded.
    fetch_ready = 1'b1;
    ex_valid = 1'b1; ex_sel = 2'd0; ex_pc = 32'h4000_0008; ex_imm = 32'h38;
    @(posedge clk);
    #1;
    check("redir_rst_pc", pc_out, RST_PC);
    check("redir_rst_flush", 32'(flush), 32'd0);
    check("redir_rst_valid", 32'(pc_valid), 32'd0);
    idle_inputs();

    // After reset the BTB is empty, so 4000_0008 falls through to +4.
    vecs.delete();
    add(1, 0, 2, 32'h0, 32'h0, 32'h0, 32'h4000_0000, 0, 0);
    add(1, 0, 2, 32'h0, 32'h0, 32'h0, 32'h4000_0004, 0, 0);
    add(1, 0, 2, 32'h0, 32'h0, 32'h0, 32'h4000_0008, 0, 0);
    add(1, 0, 2, 32'h0, 32'h0, 32'h0, 32'h4000_000C, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], 100 + i);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
